// File: rtl/ripple_count_monitor_if.sv
// Bus bundle between the ripple counter consumer and its environment.
// Ports (signals): A, dir, clear_err into the monitor; count_q, ext_count,
// valid, wrap, step_err, state (and err_count with RCM_ERR_COUNT_EN) out.
// master: environment side (drives A/dir/clear_err), slave: monitor side.
interface ripple_count_monitor_if #(
    parameter int WIDTH     = 3,
    parameter int EXT_WIDTH = 8
);
    logic [WIDTH-1:0]     A;
    logic                 dir;
    logic                 clear_err;
    logic [WIDTH-1:0]     count_q;
    logic [EXT_WIDTH-1:0] ext_count;
    logic                 valid;
    logic                 wrap;
    logic                 step_err;
    logic [1:0]           state;
`ifdef RCM_ERR_COUNT_EN
    logic [7:0]           err_count;

    modport master (
        output A, dir, clear_err,
        input  count_q, ext_count, valid, wrap, step_err, state, err_count
    );
    modport slave (
        input  A, dir, clear_err,
        output count_q, ext_count, valid, wrap, step_err, state, err_count
    );
`else
    modport master (
        output A, dir, clear_err,
        input  count_q, ext_count, valid, wrap, step_err, state
    );
    modport slave (
        input  A, dir, clear_err,
        output count_q, ext_count, valid, wrap, step_err, state
    );
`endif
endinterface

// File: rtl/ripple_count_monitor.sv
// Synchronising, glitch-filtering monitor for a ripple up/down counter.
// Ports: CLK, Reset (async, active-high), bus (slave modport):
//   A/dir/clear_err in; count_q, ext_count, valid, wrap, step_err, state out.
// Optional macro RCM_ERR_COUNT_EN adds the saturating err_count output.
module ripple_count_monitor #(
    parameter int WIDTH         = 3,
    parameter int EXT_WIDTH     = 8,
    parameter int STABLE_CYCLES = 2
) (
    input  logic                  CLK,
    input  logic                  Reset,
    ripple_count_monitor_if.slave bus
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);
    localparam logic [WIDTH-1:0] TOP = '1;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    logic [WIDTH-1:0]     r_sync1;
    logic [WIDTH-1:0]     r_sync2;
    logic [SW-1:0]        r_stab;
    logic                 r_hit;
    state_t               r_state;
    logic [WIDTH-1:0]     r_count;
    logic [EXT_WIDTH-1:0] r_ext;
    logic                 r_valid;
    logic                 r_wrap;
    logic                 r_err;

    logic                 w_chg;
    logic [SW-1:0]        w_stab_n;
    logic [WIDTH-1:0]     w_val;
    logic [WIDTH-1:0]     w_up;
    logic [WIDTH-1:0]     w_dn;
    state_t               w_state_n;
    logic [WIDTH-1:0]     w_count_n;
    logic [EXT_WIDTH-1:0] w_ext_n;
    logic                 w_valid_n;
    logic                 w_wrap_n;
    logic                 w_err_n;
    logic                 w_enter_err;

    // r_stab counts how long the value now in r_sync2 has been held.
    assign w_chg    = (r_sync1 != r_sync2);
    assign w_stab_n = w_chg ? SW'(1) :
                      (r_stab == STAB_MAX) ? r_stab : r_stab + 1'b1;

    // r_hit marks the single cycle in which the held value is accepted.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_stab  <= '0;
            r_hit   <= 1'b0;
        end else begin
            r_sync1 <= bus.A;
            r_sync2 <= r_sync1;
            r_stab  <= w_stab_n;
            r_hit   <= (w_stab_n == STAB_MAX) &&
                       ((r_stab != STAB_MAX) || w_chg);
        end
    end

    assign w_val = r_sync2;
    assign w_up  = r_count + 1'b1;
    assign w_dn  = r_count - 1'b1;

    always_comb begin
        w_state_n   = r_state;
        w_count_n   = r_count;
        w_ext_n     = r_ext;
        w_valid_n   = 1'b0;
        w_wrap_n    = 1'b0;
        w_err_n     = r_err;
        w_enter_err = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (r_hit) begin
                    w_count_n = w_val;
                    w_valid_n = 1'b1;
                    w_state_n = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (r_hit) begin
                    unique case (1'b1)
                        (w_val == r_count): begin
                        end
                        (!bus.dir && (w_val == w_up)): begin
                            w_count_n = w_val;
                            w_valid_n = 1'b1;
                            if (r_count == TOP) begin
                                w_wrap_n = 1'b1;
                                w_ext_n  = r_ext + 1'b1;
                            end
                        end
                        (bus.dir && (w_val == w_dn)): begin
                            w_count_n = w_val;
                            w_valid_n = 1'b1;
                            if (r_count == '0) begin
                                w_wrap_n = 1'b1;
                                w_ext_n  = r_ext - 1'b1;
                            end
                        end
                        default: begin
                            w_err_n     = 1'b1;
                            w_state_n   = ST_ERROR;
                            w_enter_err = 1'b1;
                        end
                    endcase
                end
            end
            ST_ERROR: begin
                // Clear beats a same-cycle acceptance, which then loads as INIT.
                if (bus.clear_err) begin
                    w_err_n   = 1'b0;
                    w_state_n = ST_INIT;
                    if (r_hit) begin
                        w_count_n = w_val;
                        w_valid_n = 1'b1;
                        w_state_n = ST_TRACK;
                    end
                end
            end
            default: begin
                w_state_n = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_INIT;
            r_count <= '0;
            r_ext   <= '0;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_count <= w_count_n;
            r_ext   <= w_ext_n;
            r_valid <= w_valid_n;
            r_wrap  <= w_wrap_n;
            r_err   <= w_err_n;
        end
    end

`ifdef RCM_ERR_COUNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_err_cnt <= '0;
        end else if (w_enter_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign bus.err_count = r_err_cnt;
`else
    logic w_unused_enter;
    assign w_unused_enter = w_enter_err;
`endif

    assign bus.count_q   = r_count;
    assign bus.ext_count = r_ext;
    assign bus.valid     = r_valid;
    assign bus.wrap      = r_wrap;
    assign bus.step_err  = r_err;
    assign bus.state     = r_state;

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Testbench for ripple_count_monitor: directed scenarios plus a randomized
// run against a step-rule reference model.
module tb_ripple_count_monitor;

    logic CLK = 1'b0;
    logic Reset;
    int   total = 0;
    int   bad   = 0;

    ripple_count_monitor_if #(.WIDTH(3), .EXT_WIDTH(8)) bus ();

    ripple_count_monitor #(
        .WIDTH(3),
        .EXT_WIDTH(8),
        .STABLE_CYCLES(2)
    ) dut (
        .CLK  (CLK),
        .Reset(Reset),
        .bus  (bus.slave)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drive A/dir and hold n cycles, counting valid and wrap pulses.
    task automatic hold(input logic [2:0] v, input logic d, input int n,
                        output int nv, output int nw);
        bus.A   = v;
        bus.dir = d;
        nv = 0;
        nw = 0;
        repeat (n) begin
            tick();
            if (bus.valid) nv++;
            if (bus.wrap) nw++;
        end
    endtask

    task automatic test_reset();
        bus.A = 3'd3;
        bus.dir = 1'b0;
        bus.clear_err = 1'b0;
        Reset = 1'b1;
        #2;
        total++; if (bus.count_q !== 3'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", bus.count_q); end
        total++; if (bus.ext_count !== 8'd0) begin bad++; $display("FAIL rst_ext: got %0d want 0", bus.ext_count); end
        total++; if (bus.valid !== 1'b0 || bus.wrap !== 1'b0) begin bad++; $display("FAIL rst_pulses: got %b%b want 00", bus.valid, bus.wrap); end
        total++; if (bus.step_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", bus.step_err); end
        total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL rst_state: got %0d want 0", bus.state); end
`ifdef RCM_ERR_COUNT_EN
        total++; if (bus.err_count !== 8'd0) begin bad++; $display("FAIL rst_errcnt: got %0d want 0", bus.err_count); end
`endif
        tick();
        Reset = 1'b0;
    endtask

    // A=3 is captured on the first edge after release; load 3 edges later.
    task automatic test_first_load();
        int first_v;
        int nv;
        int nw;
        first_v = -1;
        nv = 0;
        nw = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (bus.valid) begin
                nv++;
                if (first_v < 0) first_v = i;
            end
            if (bus.wrap) nw++;
            if (i == 4) begin
                total++; if (bus.count_q !== 3'd3) begin bad++; $display("FAIL load_count: got %0d want 3", bus.count_q); end
                total++; if (bus.state !== 2'd1) begin bad++; $display("FAIL load_state: got %0d want 1", bus.state); end
            end
        end
        total++; if (first_v != 4) begin bad++; $display("FAIL load_latency: got edge %0d want 4", first_v); end
        total++; if (nv != 1 || nw != 0) begin bad++; $display("FAIL load_pulses: got v=%0d w=%0d want v=1 w=0", nv, nw); end
    endtask

    task automatic test_up_wrap();
        int nv, nw, sv, sw;
        hold(3'd4, 1'b0, 5, nv, nw);
        hold(3'd5, 1'b0, 5, nv, nw);
        sv = 0;
        sw = 0;
        hold(3'd6, 1'b0, 4, nv, nw); sv += nv; sw += nw;
        hold(3'd7, 1'b0, 4, nv, nw); sv += nv; sw += nw;
        total++; if (sw != 0) begin bad++; $display("FAIL up_early_wrap: got %0d want 0", sw); end
        hold(3'd0, 1'b0, 4, nv, nw); sv += nv;
        total++; if (nw != 1) begin bad++; $display("FAIL up_wrap_pulse: got %0d want 1", nw); end
        total++; if (sv != 3) begin bad++; $display("FAIL up_valid_cnt: got %0d want 3", sv); end
        total++; if (bus.ext_count !== 8'd1) begin bad++; $display("FAIL up_ext: got %0d want 1", bus.ext_count); end
        total++; if (bus.count_q !== 3'd0) begin bad++; $display("FAIL up_count: got %0d want 0", bus.count_q); end
    endtask

    task automatic test_down_wrap();
        int nv, nw;
        hold(3'd7, 1'b1, 5, nv, nw);
        total++; if (nw != 1 || nv != 1) begin bad++; $display("FAIL dn_wrap1: got v=%0d w=%0d want 1 1", nv, nw); end
        total++; if (bus.ext_count !== 8'd0) begin bad++; $display("FAIL dn_ext1: got %0d want 0", bus.ext_count); end
        for (int v = 6; v >= 0; v--) hold(3'(v), 1'b1, 5, nv, nw);
        hold(3'd7, 1'b1, 5, nv, nw);
        total++; if (nw != 1) begin bad++; $display("FAIL dn_wrap2: got %0d want 1", nw); end
        total++; if (bus.ext_count !== 8'd255) begin bad++; $display("FAIL dn_ext2: got %0d want 255", bus.ext_count); end
        total++; if (bus.count_q !== 3'd7) begin bad++; $display("FAIL dn_count: got %0d want 7", bus.count_q); end
        hold(3'd0, 1'b0, 5, nv, nw);
        total++; if (bus.ext_count !== 8'd0) begin bad++; $display("FAIL dn_ext_back: got %0d want 0", bus.ext_count); end
    endtask

    task automatic test_glitch();
        int nv, nw;
        hold(3'd1, 1'b0, 5, nv, nw);
        hold(3'd2, 1'b0, 5, nv, nw);
        total++; if (bus.count_q !== 3'd2) begin bad++; $display("FAIL gl_pre: got %0d want 2", bus.count_q); end
        bus.A = 3'd0;
        tick();
        hold(3'd3, 1'b0, 6, nv, nw);
        total++; if (nv != 1) begin bad++; $display("FAIL gl_valid: got %0d want 1", nv); end
        total++; if (bus.count_q !== 3'd3) begin bad++; $display("FAIL gl_count: got %0d want 3", bus.count_q); end
        total++; if (bus.step_err !== 1'b0) begin bad++; $display("FAIL gl_err: got %b want 0", bus.step_err); end
    endtask

    task automatic test_error_clear();
        int nv, nw;
        hold(3'd2, 1'b1, 5, nv, nw);
        hold(3'd5, 1'b0, 5, nv, nw);
        total++; if (bus.step_err !== 1'b1) begin bad++; $display("FAIL er_err: got %b want 1", bus.step_err); end
        total++; if (bus.state !== 2'd2) begin bad++; $display("FAIL er_state: got %0d want 2", bus.state); end
        total++; if (bus.count_q !== 3'd2 || nv != 0) begin bad++; $display("FAIL er_count: got %0d v=%0d want 2 v=0", bus.count_q, nv); end
`ifdef RCM_ERR_COUNT_EN
        total++; if (bus.err_count !== 8'd1) begin bad++; $display("FAIL er_errcnt: got %0d want 1", bus.err_count); end
`endif
        bus.clear_err = 1'b1;
        tick();
        bus.clear_err = 1'b0;
        total++; if (bus.state !== 2'd0 || bus.step_err !== 1'b0) begin bad++; $display("FAIL er_clear: got st=%0d err=%b want 0 0", bus.state, bus.step_err); end
        bus.A = 3'd0;
        tick();
        hold(3'd5, 1'b0, 6, nv, nw);
        total++; if (nv != 1 || bus.count_q !== 3'd5) begin bad++; $display("FAIL er_resync: got v=%0d c=%0d want 1 5", nv, bus.count_q); end
        total++; if (bus.state !== 2'd1) begin bad++; $display("FAIL er_track: got %0d want 1", bus.state); end
        bus.clear_err = 1'b1;
        tick();
        bus.clear_err = 1'b0;
        total++; if (bus.state !== 2'd1 || bus.count_q !== 3'd5) begin bad++; $display("FAIL er_clr_track: got st=%0d c=%0d want 1 5", bus.state, bus.count_q); end
    endtask

    task automatic test_clear_in_accept();
        int nv, nw;
        hold(3'd1, 1'b0, 5, nv, nw);
        total++; if (bus.state !== 2'd2) begin bad++; $display("FAIL ca_err: got %0d want 2", bus.state); end
`ifdef RCM_ERR_COUNT_EN
        total++; if (bus.err_count !== 8'd2) begin bad++; $display("FAIL ca_errcnt: got %0d want 2", bus.err_count); end
`endif
        bus.A = 3'd4;
        tick();
        tick();
        tick();
        bus.clear_err = 1'b1;
        tick();
        bus.clear_err = 1'b0;
        total++; if (bus.valid !== 1'b1 || bus.count_q !== 3'd4) begin bad++; $display("FAIL ca_load: got v=%b c=%0d want 1 4", bus.valid, bus.count_q); end
        total++; if (bus.state !== 2'd1 || bus.step_err !== 1'b0) begin bad++; $display("FAIL ca_state: got st=%0d e=%b want 1 0", bus.state, bus.step_err); end
        tick();
        total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL ca_pulse_len: got %b want 0", bus.valid); end
    endtask

    task automatic test_reset_mid();
        int nv, nw;
        bus.A = 3'd6;
        tick();
        bus.A = 3'd1;
        Reset = 1'b1;
        #2;
        total++; if (bus.count_q !== 3'd0 || bus.state !== 2'd0) begin bad++; $display("FAIL rm_clear: got c=%0d st=%0d want 0 0", bus.count_q, bus.state); end
        total++; if (bus.valid !== 1'b0 || bus.step_err !== 1'b0) begin bad++; $display("FAIL rm_flags: got v=%b e=%b want 0 0", bus.valid, bus.step_err); end
        bus.A = 3'd2;
        tick();
        Reset = 1'b0;
        hold(3'd2, 1'b0, 6, nv, nw);
        total++; if (nv != 1 || bus.count_q !== 3'd2) begin bad++; $display("FAIL rm_reload: got v=%0d c=%0d want 1 2", nv, bus.count_q); end
        total++; if (bus.state !== 2'd1) begin bad++; $display("FAIL rm_state: got %0d want 1", bus.state); end
`ifdef RCM_ERR_COUNT_EN
        total++; if (bus.err_count !== 8'd0) begin bad++; $display("FAIL rm_errcnt: got %0d want 0", bus.err_count); end
`endif
    endtask

    // Each held value is one event; the model applies the step rules directly.
    task automatic test_random();
        logic [2:0] m_cnt, prev_a, v;
        logic [7:0] m_ext;
        int m_state, m_err, m_errcnt;
        int nv, nw, ev, ew, r;
        logic d, fresh, acc;
        bus.A = 3'($urandom_range(0, 7));
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        m_cnt = 3'd0;
        m_ext = 8'd0;
        m_state = 0;
        m_err = 0;
        m_errcnt = 0;
        fresh = 1'b1;
        prev_a = 3'd0;
        for (int i = 0; i < 150; i++) begin
            if (m_state == 2 && $urandom_range(0, 1) == 1) begin
                bus.clear_err = 1'b1;
                tick();
                bus.clear_err = 1'b0;
                m_state = 0;
                m_err = 0;
            end
            d = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 9);
            if (r < 6) v = 3'(m_cnt + (d ? 3'd7 : 3'd1));
            else if (r == 6) v = m_cnt;
            else v = 3'($urandom_range(0, 7));
            if (i == 0) v = bus.A;
            acc = fresh || (v != prev_a);
            fresh = 1'b0;
            prev_a = v;
            ev = 0;
            ew = 0;
            if (acc) begin
                if (m_state == 0) begin
                    m_cnt = v;
                    ev = 1;
                    m_state = 1;
                end else if (m_state == 1 && v != m_cnt) begin
                    if (v == 3'((int'(m_cnt) + (d ? 7 : 1)) % 8)) begin
                        ev = 1;
                        if (!d && m_cnt == 3'd7) begin ew = 1; m_ext = m_ext + 8'd1; end
                        if (d && m_cnt == 3'd0) begin ew = 1; m_ext = m_ext - 8'd1; end
                        m_cnt = v;
                    end else begin
                        m_state = 2;
                        m_err = 1;
                        if (m_errcnt < 255) m_errcnt++;
                    end
                end
            end
            hold(v, d, 5, nv, nw);
            total++; if (nv != ev || nw != ew) begin bad++; $display("FAIL rnd_pulses[%0d]: got v=%0d w=%0d want v=%0d w=%0d", i, nv, nw, ev, ew); end
            total++; if (bus.count_q !== m_cnt || bus.ext_count !== m_ext) begin bad++; $display("FAIL rnd_count[%0d]: got c=%0d x=%0d want c=%0d x=%0d", i, bus.count_q, bus.ext_count, m_cnt, m_ext); end
            total++; if (bus.state !== 2'(m_state) || bus.step_err !== 1'(m_err)) begin bad++; $display("FAIL rnd_state[%0d]: got st=%0d e=%b want st=%0d e=%0d", i, bus.state, bus.step_err, m_state, m_err); end
        end
`ifdef RCM_ERR_COUNT_EN
        total++; if (bus.err_count !== 8'(m_errcnt)) begin bad++; $display("FAIL rnd_errcnt: got %0d want %0d", bus.err_count, m_errcnt); end
`endif
    endtask

    initial begin
        Reset = 1'b1;
        bus.A = 3'd0;
        bus.dir = 1'b0;
        bus.clear_err = 1'b0;
        #3;
        test_reset();
        test_first_load();
        test_up_wrap();
        test_down_wrap();
        test_glitch();
        test_error_clear();
        test_clear_in_accept();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
